program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
Replaces the free-running program counter in the 1-bit processor with a controlled instruction sequencer.
- Drives the ROM address and receives the 8-bit instruction.
- Decodes a 2-bit control field for jump, conditional jump and halt.
- Gates the 4-bit opcode and an execute-enable into the ICU.
- Lets a host run, stop or single-step the program.

Parameters:
ADDR_W, 4, ROM address width; ROM depth is 2^ADDR_W; legal range 1..4.
NOP_OPC, 4'h0, opcode sent to ICU when no instruction executes.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute continuously
step  in  1  single-step request; internally rising-edge detected
instr  in  8  instruction from ROM at addr (combinational ROM)
flag_in  in  1  ICU result bit, branch condition for JMPF
addr  out  ADDR_W  ROM address (registered)
opcode  out  4  opcode to ICU; NOP_OPC when icu_en=0
icu_en  out  1  ICU executes opcode at the next rising clk edge
busy  out  1  state is RUN or STEP
halted  out  1  state is HALTED

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, addr=0, step_q=0. icu_en=0, opcode=NOP_OPC, busy=0, halted=0 immediately. Reset mid-RUN aborts the instruction; ICU sees no enable.
- Instruction fields: ctrl=instr[7:6], reserved=instr[5:4], op/target=instr[3:0]. Target = instr[ADDR_W-1:0].
- ctrl encodings: 00 SEQ, 01 JMP, 10 JMPF, 11 HALT.
- exec = state is RUN or STEP. Instruction at addr executes in the same cycle addr is presented; zero fetch latency. addr updates at the clock edge.
- SEQ when exec: icu_en=1, opcode=instr[3:0], addr<=addr+1 (modulo 2^ADDR_W).
- JMP when exec: icu_en=0, addr<=target.
- JMPF when exec: icu_en=0. flag_in=1: addr<=target. flag_in=0: addr<=addr+1.
- HALT when exec: icu_en=0, addr<=addr+1, state<=HALTED.
- Whenever icu_en=0, opcode=NOP_OPC.
- Step edge: step_rise = step & ~step_q; step_q registered every cycle.
- IDLE: run=1 -> RUN. Else step_rise -> STEP. Else stay; addr held.
- RUN: the current instruction executes. A HALT instruction takes priority. Otherwise run=0 -> IDLE; else stay RUN.
- STEP: executes exactly one instruction, then -> IDLE (HALTED if the instruction is HALT).
- HALTED: no execution; addr held. Exits to IDLE only when run=0 and step=0 in the same cycle. A host holding run high stays halted.
- JMP/JMPF to the current addr is legal: a spin loop with icu_en=0.
- step edges arriving in RUN or HALTED are discarded, not queued.

Optional Feature:
Macro SEQ_STOP_AT_END_EN.
- Defined: a SEQ or JMPF-not-taken at addr=2^ADDR_W-1 executes normally, then sets addr<=0 and enters HALTED. Applies in RUN and STEP.
- Undefined: addr wraps to 0 and sequencing continues.
- JMP/JMPF-taken are unaffected in both builds.

Decomposition:
- Package seq_pkg holds: CTRL_SEQ/CTRL_JMP/CTRL_JMPF/CTRL_HALT (2-bit), state encoding (IDLE, RUN, STEP, HALTED; 2-bit), default NOP_OPC.
- One combinational sub-module, seq_next_addr: inputs ctrl, addr, target, flag_in, exec. Outputs next_addr, at_end, halt_hit.
- FSM and step edge detection stay in program_sequencer.

Test Plan:
- Wrap: rst released, run=1, ROM all SEQ with opcode=addr[3:0] -> addr 0,1,...,15,0. icu_en=1 every cycle; opcode tracks addr. With SEQ_STOP_AT_END_EN: after addr 15 executes, addr=0, halted=1.
- JMP: ROM[2]=8'h45 -> addr 0,1,2,5,6. At addr 2, icu_en=0 and opcode=4'h0.
- JMPF: ROM[3]=8'h80. flag_in=1 -> next addr 0. flag_in=0 -> next addr 4, icu_en=0 during the JMPF cycle.
- HALT: ROM[4]=8'hC0, run held 1 -> next cycle halted=1, addr=5, icu_en=0, and stays so for 10 cycles. run=0 -> IDLE, halted=0. run=1 -> executes ROM[5].
- Step: IDLE at addr 6, step high for 3 cycles -> exactly one icu_en=1 cycle, addr=7, busy high for one cycle. Second step pulse -> addr=8.
- Reset: rst=0 asserted between edges while RUN at addr 7 -> addr=0, icu_en=0, busy=0 before the next edge. rst=1 with run=0 -> stays IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: control-field encodings,
// FSM state encoding and the default NOP opcode.
package seq_pkg;

  // Control field instr[7:6]
  localparam logic [1:0] CTRL_SEQ  = 2'b00;
  localparam logic [1:0] CTRL_JMP  = 2'b01;
  localparam logic [1:0] CTRL_JMPF = 2'b10;
  localparam logic [1:0] CTRL_HALT = 2'b11;

  // Opcode presented to the ICU whenever nothing executes
  localparam logic [3:0] NOP_OPC_DEFAULT = 4'h0;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StHalted = 2'b11
  } state_e;

endpackage

// File: rtl/seq_next_addr.sv
// Combinational next-address logic for the program sequencer.
// Holds the address when nothing executes; otherwise decodes the control
// field into sequential, jump and conditional-jump targets.
module seq_next_addr
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic [1:0]        ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] target,
  input  logic              flag_in,
  input  logic              exec,
  output logic [ADDR_W-1:0] next_addr,
  output logic              at_end,
  output logic              halt_hit
);

  logic [ADDR_W-1:0] addr_inc;
  logic              addr_last;

  assign addr_inc  = addr + ADDR_W'(1);
  assign addr_last = (addr == {ADDR_W{1'b1}});

  // Decode the executing instruction into the following ROM address
  always_comb begin
    next_addr = addr;
    at_end    = 1'b0;
    halt_hit  = 1'b0;
    if (exec) begin
      unique case (ctrl)
        CTRL_SEQ: begin
          next_addr = addr_inc;
          at_end    = addr_last;
        end
        CTRL_JMP: begin
          next_addr = target;
        end
        CTRL_JMPF: begin
          if (flag_in) begin
            next_addr = target;
          end else begin
            next_addr = addr_inc;
            at_end    = addr_last;
          end
        end
        CTRL_HALT: begin
          next_addr = addr_inc;
          halt_hit  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Controlled instruction sequencer for the 1-bit processor. Presents a
// registered ROM address, executes the returned instruction in the same
// cycle, and lets a host run, stop or single-step the program.
// Optional build macro SEQ_STOP_AT_END_EN: falling off the last ROM address
// (SEQ or JMPF-not-taken) halts with addr=0 instead of wrapping.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter logic [3:0]  NOP_OPC = NOP_OPC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic [7:0]        instr,
  input  logic              flag_in,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        opcode,
  output logic              icu_en,
  output logic              busy,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_addr;
  logic              step_q;
  logic              step_rise;
  logic              exec;
  logic [1:0]        ctrl;
  logic              at_end;
  logic              halt_hit;
  logic              stop_end;

  assign ctrl      = instr[7:6];
  assign step_rise = step & ~step_q;
  assign exec      = (state_q == StRun) || (state_q == StStep);

  // Reserved field carries no meaning yet
  logic [1:0] unused_rsvd;
  assign unused_rsvd = instr[5:4];

`ifdef SEQ_STOP_AT_END_EN
  assign stop_end = at_end;
`else
  assign stop_end = 1'b0;
  logic unused_at_end;
  assign unused_at_end = at_end;
`endif

  seq_next_addr #(
    .ADDR_W (ADDR_W)
  ) u_next_addr (
    .ctrl      (ctrl),
    .addr      (addr_q),
    .target    (instr[ADDR_W-1:0]),
    .flag_in   (flag_in),
    .exec      (exec),
    .next_addr (next_addr),
    .at_end    (at_end),
    .halt_hit  (halt_hit)
  );

  // State, address and step-history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= next_addr;
      step_q  <= step;
    end
  end

  // Next-state decode; HALT and end-of-ROM stops win over host control
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StRun;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (halt_hit || stop_end) begin
          state_d = StHalted;
        end else if (!run) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = (halt_hit || stop_end) ? StHalted : StIdle;
      end
      StHalted: begin
        if (!run && !step) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ICU interface and status outputs
  always_comb begin
    icu_en = exec && (ctrl == CTRL_SEQ);
    opcode = icu_en ? instr[3:0] : NOP_OPC;
    busy   = exec;
    halted = (state_q == StHalted);
    addr   = addr_q;
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a table of per-cycle vectors
// covering JMP, JMPF, HALT and run/stop, plus hand sequences for address
// wrap, single-step and asynchronous reset.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       step;
  logic [7:0] instr;
  logic       flag_in;
  logic [3:0] addr;
  logic [3:0] opcode;
  logic       icu_en;
  logic       busy;
  logic       halted;

  logic [7:0] rom [16];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       run;
    logic       step;
    logic       flag;
    logic [3:0] addr;
    logic       en;
    logic [3:0] op;
    logic       busy;
    logic       halted;
  } vec_t;

  vec_t vecs [32];

  always #5 clk = ~clk;

  assign instr = rom[addr];

  program_sequencer #(
    .ADDR_W  (4),
    .NOP_OPC (4'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .step    (step),
    .instr   (instr),
    .flag_in (flag_in),
    .addr    (addr),
    .opcode  (opcode),
    .icu_en  (icu_en),
    .busy    (busy),
    .halted  (halted)
  );

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [3:0] a,
                              input logic e, input logic [3:0] o, input logic b,
                              input logic h);
    vec_t v;
    v.run = r; v.step = s; v.flag = f; v.addr = a;
    v.en = e; v.op = o; v.busy = b; v.halted = h;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] a, input logic e,
                           input logic [3:0] o, input logic b, input logic h);
    check({tag, ".addr"}, {4'h0, addr}, {4'h0, a});
    check({tag, ".icu_en"}, {7'h0, icu_en}, {7'h0, e});
    check({tag, ".opcode"}, {4'h0, opcode}, {4'h0, o});
    check({tag, ".busy"}, {7'h0, busy}, {7'h0, b});
    check({tag, ".halted"}, {7'h0, halted}, {7'h0, h});
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    step = 1'b0;
    flag_in = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic load_seq_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'(i);
  endtask

  int en_cnt;
  int busy_cnt;

  initial begin
    rst = 1'b0;
    run = 1'b0;
    step = 1'b0;
    flag_in = 1'b0;
    load_seq_rom();
    #1;
    check_all("reset", 4'd0, 1'b0, 4'h0, 1'b0, 1'b0);

    // ---------------- Wrap: all-SEQ ROM with opcode = address
    do_reset();
    run = 1'b1;
    @(negedge clk);
    check_all("wrap.idle", 4'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_all($sformatf("wrap%0d", k), 4'(k), 1'b1, 4'(k), 1'b1, 1'b0);
      tick();
    end
    @(negedge clk);
`ifdef SEQ_STOP_AT_END_EN
    check_all("wrap.end", 4'd0, 1'b0, 4'h0, 1'b0, 1'b1);
`else
    check_all("wrap.end", 4'd0, 1'b1, 4'h0, 1'b1, 1'b0);
`endif

    // ---------------- Table: JMP, JMPF, HALT, run/stop
    for (int i = 0; i < 16; i++) rom[i] = 8'(i);
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    rom[2] = 8'h45;  // JMP 5
    rom[3] = 8'h80;  // JMPF 0
    rom[4] = 8'hC0;  // HALT
    rom[5] = 8'h05;
    rom[6] = 8'h43;  // JMP 3
    vecs[0]  = mk(0, 0, 0, 4'd0, 0, 4'h0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 4'd0, 0, 4'h0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 4'd0, 1, 4'h1, 1, 0);
    vecs[3]  = mk(1, 0, 0, 4'd1, 1, 4'h2, 1, 0);
    vecs[4]  = mk(1, 0, 0, 4'd2, 0, 4'h0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 4'd5, 1, 4'h5, 1, 0);
    vecs[6]  = mk(1, 0, 0, 4'd6, 0, 4'h0, 1, 0);
    vecs[7]  = mk(1, 0, 1, 4'd3, 0, 4'h0, 1, 0);
    vecs[8]  = mk(1, 0, 0, 4'd0, 1, 4'h1, 1, 0);
    vecs[9]  = mk(1, 0, 0, 4'd1, 1, 4'h2, 1, 0);
    vecs[10] = mk(1, 0, 0, 4'd2, 0, 4'h0, 1, 0);
    vecs[11] = mk(1, 0, 0, 4'd5, 1, 4'h5, 1, 0);
    vecs[12] = mk(1, 0, 0, 4'd6, 0, 4'h0, 1, 0);
    vecs[13] = mk(1, 0, 0, 4'd3, 0, 4'h0, 1, 0);
    vecs[14] = mk(1, 0, 0, 4'd4, 0, 4'h0, 1, 0);
    for (int i = 15; i < 25; i++) begin
      vecs[i] = mk(1, (i == 18 || i == 19), 0, 4'd5, 0, 4'h0, 0, 1);
    end
    vecs[25] = mk(0, 1, 0, 4'd5, 0, 4'h0, 0, 1);
    vecs[26] = mk(0, 0, 0, 4'd5, 0, 4'h0, 0, 1);
    vecs[27] = mk(0, 0, 0, 4'd5, 0, 4'h0, 0, 0);
    vecs[28] = mk(1, 0, 0, 4'd5, 0, 4'h0, 0, 0);
    vecs[29] = mk(1, 0, 0, 4'd5, 1, 4'h5, 1, 0);
    vecs[30] = mk(0, 0, 0, 4'd6, 0, 4'h0, 1, 0);
    vecs[31] = mk(0, 0, 0, 4'd3, 0, 4'h0, 0, 0);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      run = vecs[i].run;
      step = vecs[i].step;
      flag_in = vecs[i].flag;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].en, vecs[i].op,
                vecs[i].busy, vecs[i].halted);
      tick();
    end

    // ---------------- Single-step from IDLE at address 6
    load_seq_rom();
    do_reset();
    run = 1'b1;
    repeat (6) tick();
    run = 1'b0;
    tick();
    @(negedge clk);
    check_all("step.idle", 4'd6, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    en_cnt = 0;
    busy_cnt = 0;
    step = 1'b1;
    repeat (3) begin
      @(negedge clk);
      en_cnt += int'(icu_en);
      busy_cnt += int'(busy);
      tick();
    end
    step = 1'b0;
    repeat (2) begin
      @(negedge clk);
      en_cnt += int'(icu_en);
      busy_cnt += int'(busy);
      tick();
    end
    check("step.en_cycles", 8'(en_cnt), 8'd1);
    check("step.busy_cycles", 8'(busy_cnt), 8'd1);
    @(negedge clk);
    check_all("step.after1", 4'd7, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    @(negedge clk);
    check_all("step.exec2", 4'd7, 1'b1, 4'h7, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    check_all("step.after2", 4'd8, 1'b0, 4'h0, 1'b0, 1'b0);

    // ---------------- Asynchronous reset while running at address 7
    do_reset();
    run = 1'b1;
    repeat (8) tick();
    check_all("rst.pre", 4'd7, 1'b1, 4'h7, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_all("rst.async", 4'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    run = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_all("rst.idle", 4'd0, 1'b0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
